axi4_lite_regfile_slave: RTL

Parameterised AXI4-Lite slave register file. It is the next generation of the single-register slave paired with axi4_lite_master in axi4_lite_top.
- NUM_REGS word registers, each configurable read-write or read-only.
- Byte-lane WSTRB support.
- AW and W channels accepted independently and in any order.
- OKAY/SLVERR/DECERR responses.
- Read-only registers are fed from fabric inputs; read-write registers are exported to fabric with per-register write strobes.

---
 rtl/axi4_lite_pkg.sv | 28 ++
 rtl/axi4_lite_addr_decode.sv | 29 ++
 rtl/axi4_lite_regfile_slave.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register file slave.
// Response codes, read FSM states and the byte-lane merge used on writes.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Sized for the widest supported bus (64 bits); narrower callers zero-extend.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] merged;
    for (int b = 0; b < 8; b++) begin
      merged[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Combinational address decode: word index, range check and read-only lookup.
// Low address bits below the word size are ignored, so unaligned accesses alias.
module axi4_lite_addr_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic [ADDRESS-1:0] addr,
  output logic [IDX_W-1:0]   index,
  output logic               in_range,
  output logic               is_ro
);
  import axi4_lite_pkg::*;

  localparam int LSB = $clog2(DATA_WIDTH / 8);
  localparam int PAD = 1 << IDX_W;
  // Padding to a power of two keeps the mask lookup in bounds for any index value.
  localparam logic [PAD-1:0] RO_PAD = PAD'(RO_MASK);

  logic [ADDRESS-1:0] word;

  assign word     = addr >> LSB;
  assign index    = word[IDX_W-1:0];
  assign in_range = (word < ADDRESS'(NUM_REGS));
  assign is_ro    = in_range && RO_PAD[index];

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite register file: NUM_REGS words, read-write or read-only per RO_MASK.
// AW/W are buffered independently and commit together once the B slot is free.
module axi4_lite_regfile_slave
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDRESS-1:0]             S_AWADDR,
  input  logic                           S_AWVALID,
  output logic                           S_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_WSTRB,
  input  logic                           S_WVALID,
  output logic                           S_WREADY,
  output logic [1:0]                     S_BRESP,
  output logic                           S_BVALID,
  input  logic                           S_BREADY,
  input  logic [ADDRESS-1:0]             S_ARADDR,
  input  logic                           S_ARVALID,
  output logic                           S_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_RDATA,
  output logic [1:0]                     S_RRESP,
  output logic                           S_RVALID,
  input  logic                           S_RREADY,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            wr_stb
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                  rst_done_reg;
  logic                  aw_full_reg, w_full_reg;
  logic [ADDRESS-1:0]    aw_addr_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic [STRB_W-1:0]     w_strb_reg;
  logic                  bvalid_reg;
  resp_t                 bresp_reg, wr_resp;
  logic [NUM_REGS-1:0]   wr_stb_reg, stb_hit;
  rd_state_t             rd_state_reg;
  logic [DATA_WIDTH-1:0] rdata_reg, rd_word;
  resp_t                 rresp_reg;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat;

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_in_range, wr_is_ro, rd_in_range, rd_is_ro;
  logic             commit;

  axi4_lite_addr_decode #(
    .DATA_WIDTH(DATA_WIDTH), .ADDRESS(ADDRESS), .NUM_REGS(NUM_REGS),
    .IDX_W(IDX_W), .RO_MASK(RO_MASK)
  ) u_wr_dec (
    .addr(aw_addr_reg), .index(wr_idx), .in_range(wr_in_range), .is_ro(wr_is_ro)
  );

  axi4_lite_addr_decode #(
    .DATA_WIDTH(DATA_WIDTH), .ADDRESS(ADDRESS), .NUM_REGS(NUM_REGS),
    .IDX_W(IDX_W), .RO_MASK(RO_MASK)
  ) u_rd_dec (
    .addr(S_ARADDR), .index(rd_idx), .in_range(rd_in_range), .is_ro(rd_is_ro)
  );

  // Readies stay low until the first edge after reset release.
  assign S_AWREADY = rst_done_reg && !aw_full_reg;
  assign S_WREADY  = rst_done_reg && !w_full_reg;
  assign S_ARREADY = rst_done_reg && (rd_state_reg == R_IDLE);
  assign S_BVALID  = bvalid_reg;
  assign S_BRESP   = bresp_reg;
  assign S_RVALID  = (rd_state_reg == R_DATA);
  assign S_RDATA   = rdata_reg;
  assign S_RRESP   = rresp_reg;
  assign wr_stb    = wr_stb_reg;
  assign regs_out  = regs_flat;

  assign commit = aw_full_reg && w_full_reg && !bvalid_reg;

  always_comb begin
    wr_resp = OKAY;
    if (!wr_in_range)  wr_resp = DECERR;
    else if (wr_is_ro) wr_resp = SLVERR;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign stb_hit[gi] = commit && wr_in_range && !wr_is_ro && (wr_idx == IDX_W'(gi));
      if (RO_MASK[gi]) begin : g_ro
        assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] q_reg;
        always_ff @(posedge ACLK or posedge ARESET) begin
          if (ARESET) begin
            q_reg <= RESET_VAL;
          end else if (stb_hit[gi]) begin
            q_reg <= DATA_WIDTH'(strb_merge(64'(q_reg), 64'(w_data_reg), 8'(w_strb_reg)));
          end
        end
        assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;
      end
    end
  endgenerate

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rst_done_reg <= 1'b0;
      aw_full_reg  <= 1'b0;
      w_full_reg   <= 1'b0;
      aw_addr_reg  <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= OKAY;
      wr_stb_reg   <= '0;
    end else begin
      rst_done_reg <= 1'b1;
      wr_stb_reg   <= stb_hit;
      if (commit) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_resp;
      end else if (bvalid_reg && S_BREADY) begin
        bvalid_reg <= 1'b0;
      end
      if (S_AWVALID && S_AWREADY) begin
        aw_full_reg <= 1'b1;
        aw_addr_reg <= S_AWADDR;
      end
      if (S_WVALID && S_WREADY) begin
        w_full_reg <= 1'b1;
        w_data_reg <= S_WDATA;
        w_strb_reg <= S_WSTRB;
      end
    end
  end

  // Register contents are sampled before this edge's commit lands, so a
  // colliding read returns the pre-write value.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = rd_is_ro ? ro_in[rd_idx*DATA_WIDTH +: DATA_WIDTH]
                         : regs_flat[rd_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_reg <= R_IDLE;
      rdata_reg    <= '0;
      rresp_reg    <= OKAY;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (S_ARVALID && S_ARREADY) begin
            rd_state_reg <= R_DATA;
            rdata_reg    <= rd_word;
            rresp_reg    <= rd_in_range ? OKAY : DECERR;
          end
        end
        R_DATA: begin
          if (S_RREADY) rd_state_reg <= R_IDLE;
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

endmodule
